// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
// Address/data widths and the pending write-back request bundle.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending mult/div write-back queue with per-entry valid bits,
// kill-by-address and a youngest-match forwarding search.
module wb_pend_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_req_t                 push_req,
  input  logic                    pop,
  input  logic                    kill_en,
  input  logic [REG_ADDR_W-1:0]   kill_rw,
  input  logic [REG_ADDR_W-1:0]   q_rw,
  output wb_req_t                 head,
  output logic                    full,
  output logic                    empty,
  output logic                    hit,
  output logic [DATA_W-1:0]       hit_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t        mem_q [DEPTH];
  wb_req_t        mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  idx;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Next storage state: kill matches, retire popped slot, then write
  // the pushed entry (which is killed too if it matches the ALU target).
  always_comb begin
    mem_d = mem_q;
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rw == kill_rw) begin
          mem_d[i].valid = 1'b0;
        end
      end
    end
    if (pop) begin
      mem_d[rd_ptr_q].valid = 1'b0;
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_req;
      if (kill_en && (push_req.rw == kill_rw)) begin
        mem_d[wr_ptr_q].valid = 1'b0;
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && mem_q[idx].valid &&
          (mem_q[idx].rw == q_rw)) begin
        hit      = 1'b1;
        hit_data = mem_q[idx].data;
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: ALU path has priority, mult/div
// results queue behind it, with WAW kill, anti-starvation and forwarding.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int W          = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  AluWrEn,
  input  logic [REG_ADDR_W-1:0] AluRw,
  input  logic [W-1:0]          AluBus,
  output logic                  AluStall,
  input  logic                  MdValid,
  input  logic [REG_ADDR_W-1:0] MdRw,
  input  logic [W-1:0]          MdBus,
  output logic                  MdReady,
  output logic                  WrEn,
  output logic [REG_ADDR_W-1:0] Rw,
  output logic [W-1:0]          busW,
  input  logic [REG_ADDR_W-1:0] Rq,
  output logic                  FwdHit,
  output logic [W-1:0]          FwdData
);

  localparam int SW = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;

  wb_req_t               fifo_head;
  wb_req_t               push_req;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_hit;
  logic [DATA_W-1:0]     fifo_hit_data;

  logic                  alu_go;
  logic                  blocked;
  logic                  pop;
  logic                  md_push;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] rw_q, rw_d;
  logic [W-1:0]          bus_q, bus_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic                  stall_q, stall_d;

  // A stalled ALU request is ignored; r0 writes never compete.
  assign alu_go  = AluWrEn && (AluRw != '0) && !stall_q;
  assign blocked = alu_go && !fifo_empty;
  assign pop     = !alu_go && !fifo_empty;
  assign MdReady = !fifo_full;
  assign md_push = MdValid && MdReady && (MdRw != '0);

  assign push_req.valid = 1'b1;
  assign push_req.rw    = MdRw;
  assign push_req.data  = DATA_W'(MdBus);

  wb_pend_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (md_push),
    .push_req (push_req),
    .pop      (pop),
    .kill_en  (alu_go),
    .kill_rw  (AluRw),
    .q_rw     (Rq),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .hit      (fifo_hit),
    .hit_data (fifo_hit_data)
  );

  // Pick this cycle's write: ALU first, else a live FIFO head.
  always_comb begin
    wr_en_d = 1'b0;
    rw_d    = '0;
    bus_d   = '0;
    unique case (1'b1)
      alu_go: begin
        wr_en_d = 1'b1;
        rw_d    = AluRw;
        bus_d   = AluBus;
      end
      (pop && fifo_head.valid): begin
        wr_en_d = 1'b1;
        rw_d    = fifo_head.rw;
        bus_d   = W'(fifo_head.data);
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase
  end

  // Count ALU wins over a waiting queue; stall holds until it drains.
  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || pop) begin
      cnt_d = '0;
    end else if (blocked && (cnt_q != SW'(STARVE_MAX - 1))) begin
      cnt_d = cnt_q + SW'(1);
    end
    if (stall_q) begin
      stall_d = !fifo_empty;
    end else begin
      stall_d = blocked && (cnt_q == SW'(STARVE_MAX - 1));
    end
  end

  // Forward the youngest queued value, else the in-flight write.
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    if (Rq != '0) begin
      if (fifo_hit) begin
        FwdHit  = 1'b1;
        FwdData = W'(fifo_hit_data);
      end else if (wr_en_q && (rw_q == Rq)) begin
        FwdHit  = 1'b1;
        FwdData = bus_q;
      end
    end
  end

  // Output register and starvation state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_en_q <= 1'b0;
      rw_q    <= '0;
      bus_q   <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      rw_q    <= rw_d;
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign WrEn     = wr_en_q;
  assign Rw       = rw_q;
  assign busW     = bus_q;
  assign AluStall = stall_q;

endmodule
